// File: rtl/i2c_slave_pkg.sv
// Shared I2C definitions: FSM state encodings, ACK/NACK bit levels and the
// default target address. Also imported by the companion i2c_master.
package i2c_slave_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h42;

  // Bus level of the 9th (acknowledge) bit
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // FSM encodings, also exported on state_ind for debug LEDs
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_REG       = 4'd3;
  localparam logic [3:0] ST_REG_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-flop synchronizer with a third history flop for edge detection.
// Ports: clk/rst_n system clock and async active-low reset; d_i asynchronous
// pin; lvl_o synchronized level; rise_o/fall_o one-clk edge pulses.
// Flops reset to RST_VAL so an idle-high bus line gives no edge after reset.
module i2c_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= {3{RST_VAL}};
    else        sh_q <= {sh_q[1:0], d_i};
  end

  assign lvl_o  = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint with an 8-bit register-pointer interface.
// Ports: clk/rst_n system clock, async active-low reset; scl bus clock in;
// sda open-drain bus data; reg_addr register pointer; wr_data/wr_en write
// strobe to the register file; rd_data register file read data; busy high
// while addressed; state_ind current FSM state.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] state_ind
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (.clk(clk), .rst_n(rst_n), .d_i(scl),
                       .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst_n(rst_n), .d_i(sda),
                       .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  // SDA moving while SCL is high is a bus condition, never data
  logic start_ev, stop_ev;
  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;      // SCL rises seen in the current byte, 0..8
  logic [7:0] sr_q, sr_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdat_q, wdat_d;
  logic       wen_q, wen_d;

  logic addr_hit;
  // Address 0 (general call) is never claimed
  assign addr_hit = (sr_q[7:1] == SLAVE_ADDR) && (sr_q[7:1] != 7'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    wdat_d  = wdat_q;
    wen_d   = 1'b0;

    // Post-write increment lands the cycle after the strobe
    if (wen_q) ptr_d = ptr_q + 8'd1;

    if (start_ev) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_ev) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_lvl};
            cnt_d = cnt_q + 4'd1;
            if (state_q == ST_WDATA && cnt_q == 4'd7) begin
              wdat_d = {sr_q[6:0], sda_lvl};
              wen_d  = 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (addr_hit) begin
                state_d = ST_ADDR_ACK;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
                rw_d    = sr_q[0];
              end else begin
                state_d = ST_IDLE;
              end
            end else if (state_q == ST_REG) begin
              ptr_d   = sr_q;
              state_d = ST_REG_ACK;
              oe_d    = 1'b1;
            end else begin
              state_d = ST_WDATA_ACK;
              oe_d    = 1'b1;
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (state_q == ST_ADDR_ACK && rw_q) begin
              // Read: load the first byte and put its MSB on the bus now
              state_d = ST_RDATA;
              sr_d    = rd_data;
              oe_d    = ~rd_data[7];
            end else begin
              state_d = (state_q == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
              oe_d    = 1'b0;
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d   = 4'd0;
              oe_d    = 1'b0;
              state_d = ST_RDATA_ACK;
            end else begin
              sr_d = {sr_q[6:0], 1'b0};
              oe_d = ~sr_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_NACK) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + 8'd1;
            end
          end else if (scl_fall) begin
            // Only reached after an ACK; pointer updated long before
            state_d = ST_RDATA;
            sr_d    = rd_data;
            oe_d    = ~rd_data[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= 8'd0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= 8'd0;
      wdat_q  <= 8'd0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      wdat_q  <= wdat_d;
      wen_q   <= wen_d;
    end
  end

  // Open drain: pull low or release, never drive high
  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = ptr_q;
  assign wr_data   = wdat_q;
  assign wr_en     = wen_q;
  assign busy      = busy_q;
  assign state_ind = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;
  import i2c_slave_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  wire  sda;
  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;

  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_en, busy;
  logic [3:0] state_ind;

  // Register file model: fixed contents known to the bench
  logic [7:0] mem [256];
  assign rd_data = mem[reg_addr];

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda),
    .reg_addr(reg_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_data(rd_data), .busy(busy), .state_ind(state_ind)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected register writes {addr, data}, produced by the transaction model
  logic [15:0] exp_wr[$];
  logic [15:0] e_wr;
  logic        wen_prev = 1'b0;
  logic [7:0]  wa_inc;
  bit          busy_seen, slave_low;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1;
      if (sda_m && sda === 1'b0) slave_low = 1;
      if (wen_prev) chk("ptr_inc_after_wr", 32'(reg_addr), 32'(wa_inc));
      if (wr_en) begin
        chk("wr_en_width", 32'(wen_prev), 32'd0);
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL wr_unexpected: got %h:%h expected no write", reg_addr, wr_data);
        end else begin
          e_wr = exp_wr.pop_front();
          chk("wr_pair", 32'({reg_addr, wr_data}), 32'(e_wr));
        end
        wa_inc = reg_addr + 8'd1;
      end
      wen_prev = wr_en;
    end else begin
      wen_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master ----------------
  task automatic qd;
    repeat (10) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_m = b; qd;
    scl_m = 1'b1; qd;
    r = sda; qd;
    scl_m = 1'b0; qd;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; qd;
    scl_m = 1'b1; qd;
    sda_m = 1'b0; qd;
    scl_m = 1'b0; qd;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; qd;
    scl_m = 1'b1; qd;
    sda_m = 1'b1; qd;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, r);
    ack = (r == I2C_ACK);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      b[i] = r;
    end
    bit_x(mack ? I2C_ACK : I2C_NACK, r);
  endtask

  // ---------------- transaction-level model ----------------
  task automatic do_write(input logic [7:0] p0, input int n);
    logic [7:0] p, d;
    logic a;
    p = p0;
    i2c_start;
    wbyte(8'h84, a); chk("wr_addr_ack", 32'(a), 32'd1);
    wbyte(p0, a);    chk("wr_ptr_ack", 32'(a), 32'd1);
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      exp_wr.push_back({p, d});
      wbyte(d, a); chk("wr_data_ack", 32'(a), 32'd1);
      p = p + 8'd1;
    end
    i2c_stop; qd;
    chk("wr_final_ptr", 32'(reg_addr), 32'(p));
    chk("wr_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] p0, input int n);
    logic [7:0] p, b;
    logic a;
    p = p0;
    i2c_start;
    wbyte(8'h84, a); chk("rd_waddr_ack", 32'(a), 32'd1);
    wbyte(p0, a);    chk("rd_ptr_ack", 32'(a), 32'd1);
    i2c_start;
    wbyte(8'h85, a); chk("rd_raddr_ack", 32'(a), 32'd1);
    chk("rd_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      rbyte(i < n - 1, b);
      chk("rd_byte", 32'(b), 32'(mem[p]));
      if (i < n - 1) p = p + 8'd1;
    end
    chk("rd_nack_idle", 32'(state_ind), 32'(ST_IDLE));
    chk("rd_sda_released", 32'(sda), 32'd1);
    i2c_stop; qd;
    chk("rd_final_ptr", 32'(reg_addr), 32'(p));
  endtask

  typedef struct {
    logic [7:0] ab;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    logic [7:0] exp_ptr;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic a, r;
    logic [7:0] p, rp;
    int n;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11) ^ 8'h5A;

    vt[0] = '{8'h84, 8'h10, 8'hA5, 8'h5A, 1'b1, 8'h12};  // plain write
    vt[1] = '{8'h84, 8'hFF, 8'h01, 8'h02, 1'b1, 8'h01};  // pointer wrap
    vt[2] = '{8'h90, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h01};  // wrong address
    vt[3] = '{8'h00, 8'h33, 8'h00, 8'h00, 1'b0, 8'h01};  // general call
    vt[4] = '{8'h86, 8'h44, 8'h00, 8'h00, 1'b0, 8'h01};  // neighbour address

    #1;
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_ind), 32'(ST_IDLE));
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);

    for (int k = 0; k < 5; k++) begin
      busy_seen = 0;
      slave_low = 0;
      if (vt[k].exp_ack) begin
        p = vt[k].ptr;
        exp_wr.push_back({p, vt[k].d0});
        p = p + 8'd1;
        exp_wr.push_back({p, vt[k].d1});
      end
      i2c_start;
      wbyte(vt[k].ab, a);  chk("vec_addr_ack", 32'(a), 32'(vt[k].exp_ack));
      wbyte(vt[k].ptr, a); chk("vec_ptr_ack", 32'(a), 32'(vt[k].exp_ack));
      if (vt[k].exp_ack) begin
        wbyte(vt[k].d0, a); chk("vec_d0_ack", 32'(a), 32'd1);
        wbyte(vt[k].d1, a); chk("vec_d1_ack", 32'(a), 32'd1);
      end
      i2c_stop; qd;
      chk("vec_final_ptr", 32'(reg_addr), 32'(vt[k].exp_ptr));
      chk("vec_wr_drained", 32'(exp_wr.size()), 32'd0);
      chk("vec_busy_seen", 32'(busy_seen), 32'(vt[k].exp_ack));
      chk("vec_sda_driven", 32'(slave_low), 32'(vt[k].exp_ack));
      chk("vec_idle", 32'(state_ind), 32'(ST_IDLE));
    end

    // Pointer write, repeated START, read: ACK one byte then NACK
    do_read(8'h20, 2);

    // START after 4 bits of a data byte, then a fresh transaction
    i2c_start;
    wbyte(8'h84, a);
    wbyte(8'h30, a);
    for (int i = 0; i < 4; i++) bit_x(1'b1 ^ i[0], r);
    i2c_start;
    wbyte(8'h84, a); chk("abort_readdr_ack", 32'(a), 32'd1);
    wbyte(8'h40, a);
    exp_wr.push_back({8'h40, 8'h77});
    wbyte(8'h77, a); chk("abort_data_ack", 32'(a), 32'd1);
    i2c_stop; qd;
    chk("abort_wr_drained", 32'(exp_wr.size()), 32'd0);
    chk("abort_final_ptr", 32'(reg_addr), 32'h41);

    // Randomized transactions against the model
    for (int t = 0; t < 8; t++) begin
      rp = 8'($urandom);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) do_read(rp, n);
      else do_write(rp, n);
    end

    // Reset while the slave is driving the address ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) begin
      p = 8'h84;
      bit_x(p[i], r);
    end
    sda_m = 1'b1;
    @(negedge clk);
    chk("rst_pre_ack_low", 32'(sda), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sda", 32'(sda), 32'd1);
    chk("rst_mid_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_mid_wr_data", 32'(wr_data), 32'd0);
    chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_state", 32'(state_ind), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qd;
    scl_m = 1'b1;
    qd;
    chk("rst_post_state", 32'(state_ind), 32'(ST_IDLE));
    chk("rst_post_sda", 32'(sda), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
